// File: rtl/sim_run_ctrl_if.sv
// sim_run_ctrl_if: control/status bundle between the run controller
// and the simulation top that drives and observes it.
interface sim_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [CNT_W-1:0] max_cycles;
  logic             activity;
  logic             dut_reset;
  logic             run_en;
  logic [CNT_W-1:0] cycle_count;
  logic             done;
  logic             timeout;
  logic [2:0]       state;

  modport master (
    output start,
    output max_cycles,
    output activity,
    input  dut_reset,
    input  run_en,
    input  cycle_count,
    input  done,
    input  timeout,
    input  state
  );

  modport slave (
    input  start,
    input  max_cycles,
    input  activity,
    output dut_reset,
    output run_en,
    output cycle_count,
    output done,
    output timeout,
    output state
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: sequences DUT reset, a bounded run window and drain,
// with an activity watchdog that ends a hung run with a timeout.
module sim_run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int RESET_CYCLES = 4,
  parameter int WDOG_CYCLES  = 1000,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  sim_run_ctrl_if.slave bus
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int WW = $clog2(WDOG_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [WW-1:0]    wdog_q, wdog_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             drst_q, drst_d;
  logic             ren_q, ren_d;

  // Register state, counters and the registered output decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      drain_q <= '0;
      wdog_q  <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      drst_q  <= 1'b1;
      ren_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      drain_q <= drain_d;
      wdog_q  <= wdog_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      drst_q  <= drst_d;
      ren_q   <= ren_d;
    end
  end

  // Next-state logic; the watchdog is evaluated last so it wins over max hit.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    drain_d = drain_q;
    wdog_d  = wdog_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          max_d   = bus.max_cycles;
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          cnt_d   = '0;
          wdog_d  = '0;
          state_d = RUN;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == max_q) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bus.activity) begin
          wdog_d = '0;
        end else if (wdog_q == WDOG_LAST) begin
          tmo_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    drst_d = (state_d == IDLE) || (state_d == HOLD);
    ren_d  = (state_d == RUN);
  end

  assign bus.state       = state_q;
  assign bus.dut_reset   = drst_q;
  assign bus.run_en      = ren_q;
  assign bus.cycle_count = cnt_q;
  assign bus.done        = done_q;
  assign bus.timeout     = tmo_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed scenarios for the run controller, one
// instance with the default watchdog and one with a 3-cycle watchdog.
module tb_sim_run_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] max_cycles = '0;
  logic        activity = 1'b0;
  bit          sel = 1'b0;

  int total = 0;
  int bad = 0;
  int hold_n, run_n, drain_n, ovl;

  sim_run_ctrl_if #(.CNT_W(32)) ifa ();
  sim_run_ctrl_if #(.CNT_W(32)) ifb ();

  assign ifa.start      = start;
  assign ifa.max_cycles = max_cycles;
  assign ifa.activity   = activity;
  assign ifb.start      = start;
  assign ifb.max_cycles = max_cycles;
  assign ifb.activity   = activity;

  sim_run_ctrl u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  sim_run_ctrl #(.WDOG_CYCLES(3)) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  wire [2:0]  st   = sel ? ifb.state : ifa.state;
  wire        drst = sel ? ifb.dut_reset : ifa.dut_reset;
  wire        ren  = sel ? ifb.run_en : ifa.run_en;
  wire [31:0] cc   = sel ? ifb.cycle_count : ifa.cycle_count;
  wire        dn   = sel ? ifb.done : ifa.done;
  wire        tmo  = sel ? ifb.timeout : ifa.timeout;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // am: 0 activity high, 1 activity low, 2 high every third RUN cycle
  task automatic run_seq(input logic [31:0] mx, input int am,
                         input bit pester);
    bit fin;
    max_cycles = mx;
    activity = (am == 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hold_n = 0;
    run_n = 0;
    drain_n = 0;
    ovl = 0;
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      if (st == S_DONE) begin
        fin = 1'b1;
      end else begin
        if (st == S_HOLD) hold_n++;
        if (st == S_DRAIN) drain_n++;
        if (ren) run_n++;
        if (ren && drst) ovl++;
        if (am == 0) activity = 1'b1;
        else if (am == 1) activity = 1'b0;
        else activity = ren && (run_n % 3 == 0);
        start = pester && ((st == S_HOLD && hold_n == 2) ||
                           (ren && run_n == 3));
        if (pester) max_cycles = 32'd50;
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("run_bound", 64'(fin), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("done_sticky_state", 64'(st), 64'(S_DONE));
  endtask

  task automatic chk_end(input string sc, input int eh, input int er,
                         input int ed, input logic [31:0] ecc,
                         input bit et);
    chk({sc, "_hold"}, 64'(hold_n), 64'(eh));
    chk({sc, "_run"}, 64'(run_n), 64'(er));
    chk({sc, "_drain"}, 64'(drain_n), 64'(ed));
    chk({sc, "_cc"}, 64'(cc), 64'(ecc));
    chk({sc, "_done"}, 64'(dn), 64'd1);
    chk({sc, "_timeout"}, 64'(tmo), 64'(et));
    chk({sc, "_runen"}, 64'(ren), 64'd0);
    chk({sc, "_dutrst"}, 64'(drst), 64'd0);
    chk({sc, "_rst_in_run"}, 64'(ovl), 64'd0);
  endtask

  task automatic chk_idle(input string sc);
    chk({sc, "_state"}, 64'(st), 64'(S_IDLE));
    chk({sc, "_dutrst"}, 64'(drst), 64'd1);
    chk({sc, "_runen"}, 64'(ren), 64'd0);
    chk({sc, "_cc"}, 64'(cc), 64'd0);
    chk({sc, "_done"}, 64'(dn), 64'd0);
    chk({sc, "_timeout"}, 64'(tmo), 64'd0);
  endtask

  initial begin
    bit hit;
    sel = 1'b0;
    do_reset();
    chk_idle("rst");

    run_seq(32'd5, 0, 1'b0);
    chk_end("s1", 4, 6, 8, 32'd5, 1'b0);

    do_reset();
    run_seq(32'd0, 0, 1'b0);
    chk_end("s2", 4, 1, 8, 32'd0, 1'b0);

    sel = 1'b1;
    do_reset();
    chk_idle("rst_b");
    run_seq(32'd100, 1, 1'b0);
    chk_end("s3", 4, 3, 0, 32'd3, 1'b1);

    do_reset();
    run_seq(32'd2, 1, 1'b0);
    chk_end("s4", 4, 3, 0, 32'd2, 1'b1);

    do_reset();
    run_seq(32'd5, 2, 1'b0);
    chk_end("wd_clr", 4, 6, 8, 32'd5, 1'b0);

    do_reset();
    run_seq(32'hFFFF_FFFF, 1, 1'b0);
    chk_end("allones", 4, 3, 0, 32'd3, 1'b1);

    sel = 1'b0;
    do_reset();
    run_seq(32'd5, 0, 1'b1);
    chk_end("s5", 4, 6, 8, 32'd5, 1'b0);

    do_reset();
    max_cycles = 32'd5;
    activity = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (ren && cc == 32'd3) hit = 1'b1;
      else @(negedge clk);
    end
    chk("s6_reach", 64'(hit), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("s6");
    reset = 1'b0;
    @(negedge clk);
    run_seq(32'd5, 0, 1'b0);
    chk_end("s6b", 4, 6, 8, 32'd5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
